// File: rtl/stream_demux_pkg.sv
// Shared constants and state encoding for the TS multiplex receive path.
// Encodings are fixed because state_mon exposes them to software.
package stream_demux_pkg;

  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  localparam int         TS_PKT_LEN   = 188;
  localparam int         MUX_HDR_LEN  = 4;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HEADER  = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/stream_demux_hdr_capture.sv
// Routing header capture: 4-byte shift register (newest byte enters at [31:24])
// plus a holding register that freezes the header when a packet is locked.
module stream_demux_hdr_capture (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  input  logic        latch_en,
  output logic [31:0] shreg,
  output logic [31:0] hdr
);

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      shreg <= '0;
      hdr   <= '0;
    end else begin
      if (shift_en) shreg <= {byte_in, shreg[31:8]};
      if (latch_en) hdr   <= shreg;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Receive-side demultiplexer: strips the routing header from each frame and
// steers the 188-byte TS packet into the channel FIFO selected by that header.
//
// state   | meaning
// HUNT    | no lock; waiting for a P_SYNC-qualified 0x47
// PAYLOAD | writing packet bytes to channel ch
// HEADER  | counting routing header bytes before the next sync
// DROP    | consuming a packet whose FIFO had no room
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int PKT_LEN = TS_PKT_LEN,
  parameter int HDR_LEN = MUX_HDR_LEN,
  parameter int CH_LSB  = 0
) (
  input  logic        SYS_CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  input  logic        P_SYNC_IN,
  input  logic [3:0]  FIFO_ROOM_OK,
  output logic [7:0]  DATA_OUT,
  output logic [3:0]  WR_REQ,
  output logic        P_SYNC_OUT,
  output logic [3:0]  PKT_DONE,
  output logic [3:0]  PKT_ABORT,
  output logic [31:0] HDR_OUT,
  output logic        HDR_VALID,
  output logic        ERR_SYNC,
  output logic [15:0] DROP_CNT,
  output logic [1:0]  state_mon
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [7:0] HDR_CNT  = 8'(HDR_LEN);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ch_q, ch_d;
  logic [3:0]  done_pend_q, done_pend_d;
  logic [3:0]  wr_d, abort_d;
  logic        psync_d, err_d, hv_d, drop_inc;
  logic        shift_en, latch_en, start, sync_ok;
  logic [31:0] shreg;
  logic [1:0]  new_ch;

  assign sync_ok = P_SYNC_IN && (DATA_IN == TS_SYNC_BYTE);
  assign new_ch  = shreg[CH_LSB +: 2];

  stream_demux_hdr_capture u_hdr (
    .SYS_CLK  (SYS_CLK),
    .RST      (RST),
    .shift_en (shift_en),
    .byte_in  (DATA_IN),
    .latch_en (latch_en),
    .shreg    (shreg),
    .hdr      (HDR_OUT)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    done_pend_d = '0;
    wr_d        = '0;
    abort_d     = '0;
    psync_d     = 1'b0;
    err_d       = 1'b0;
    hv_d        = 1'b0;
    drop_inc    = 1'b0;
    start       = 1'b0;
    latch_en    = 1'b0;
    // an accepted sync byte is not shifted, so the captured header stays intact
    shift_en    = D_VALID_IN && !sync_ok &&
                  ((state_q == ST_HUNT) || (state_q == ST_HEADER));

    if (D_VALID_IN) begin
      unique case (state_q)
        ST_HUNT: begin
          if (sync_ok)        start = 1'b1;
          else if (P_SYNC_IN) err_d = 1'b1;
        end
        ST_PAYLOAD, ST_DROP: begin
          if (P_SYNC_IN) begin
            err_d = 1'b1;
            if (state_q == ST_PAYLOAD) abort_d = ch_onehot(ch_q);
            if (sync_ok) start = 1'b1;
            else         state_d = ST_HUNT;
          end else begin
            if (state_q == ST_PAYLOAD) wr_d = ch_onehot(ch_q);
            if (cnt_q == LAST_IDX) begin
              if (state_q == ST_PAYLOAD) done_pend_d = ch_onehot(ch_q);
              cnt_d   = '0;
              state_d = ST_HEADER;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_HEADER: begin
          if (P_SYNC_IN) begin
            if (cnt_q != HDR_CNT) err_d = 1'b1;
            if (sync_ok) start = 1'b1;
            else begin
              err_d   = 1'b1;
              state_d = ST_HUNT;
            end
          end else if (cnt_q == HDR_CNT) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      if (start) begin
        latch_en = 1'b1;
        hv_d     = 1'b1;
        ch_d     = new_ch;
        cnt_d    = 8'd1;
        if (FIFO_ROOM_OK[new_ch]) begin
          wr_d    = ch_onehot(new_ch);
          psync_d = 1'b1;
          state_d = ST_PAYLOAD;
        end else begin
          drop_inc = 1'b1;
          state_d  = ST_DROP;
        end
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_HUNT;
      cnt_q       <= '0;
      ch_q        <= '0;
      done_pend_q <= '0;
      DATA_OUT    <= '0;
      WR_REQ      <= '0;
      P_SYNC_OUT  <= 1'b0;
      PKT_DONE    <= '0;
      PKT_ABORT   <= '0;
      HDR_VALID   <= 1'b0;
      ERR_SYNC    <= 1'b0;
      DROP_CNT    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      done_pend_q <= done_pend_d;
      if (|wr_d) DATA_OUT <= DATA_IN;
      WR_REQ      <= wr_d;
      P_SYNC_OUT  <= psync_d;
      PKT_DONE    <= done_pend_q;
      PKT_ABORT   <= abort_d;
      HDR_VALID   <= hv_d;
      ERR_SYNC    <= err_d;
      if (drop_inc && (DROP_CNT != 16'hFFFF)) DROP_CNT <= DROP_CNT + 16'd1;
    end
  end

  assign state_mon = state_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed/randomized bench for stream_demux: expected write stream, headers and
// pulse counts are built per frame from the framing rules and compared every cycle.
module tb_stream_demux;

  logic        SYS_CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA_IN = '0;
  logic        D_VALID_IN = 1'b0;
  logic        P_SYNC_IN = 1'b0;
  logic [3:0]  FIFO_ROOM_OK = 4'hF;
  logic [7:0]  DATA_OUT;
  logic [3:0]  WR_REQ;
  logic        P_SYNC_OUT;
  logic [3:0]  PKT_DONE;
  logic [3:0]  PKT_ABORT;
  logic [31:0] HDR_OUT;
  logic        HDR_VALID;
  logic        ERR_SYNC;
  logic [15:0] DROP_CNT;
  logic [1:0]  state_mon;

  stream_demux dut (
    .SYS_CLK(SYS_CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN),
    .P_SYNC_IN(P_SYNC_IN), .FIFO_ROOM_OK(FIFO_ROOM_OK), .DATA_OUT(DATA_OUT),
    .WR_REQ(WR_REQ), .P_SYNC_OUT(P_SYNC_OUT), .PKT_DONE(PKT_DONE),
    .PKT_ABORT(PKT_ABORT), .HDR_OUT(HDR_OUT), .HDR_VALID(HDR_VALID),
    .ERR_SYNC(ERR_SYNC), .DROP_CNT(DROP_CNT), .state_mon(state_mon)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       sop;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] exp_hdr_q[$];
  int checks = 0, errors = 0;
  int wcnt[4], n_done[4], n_abort[4], exp_done[4], exp_abort[4];
  int n_err = 0, exp_err = 0, exp_drop = 0, gap_pct = 0;
  logic       prev_wr = 1'b0;
  logic [1:0] prev_ch = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    wr_t        e;
    logic [3:0] oh;
    if (WR_REQ != 4'b0) begin
      if (exp_q.size() == 0) chk("wr_unexpected", 32'(WR_REQ), 32'h0);
      else begin
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.ch;
        chk("wr_req", 32'(WR_REQ), 32'(oh));
        chk("data_out", 32'(DATA_OUT), 32'(e.data));
        chk("p_sync_out", 32'(P_SYNC_OUT), 32'(e.sop));
        if (e.sop) wcnt[e.ch] = 1;
        else       wcnt[e.ch]++;
      end
    end else begin
      chk("p_sync_idle", 32'(P_SYNC_OUT), 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      if (PKT_DONE[c]) begin
        n_done[c]++;
        chk("done_len", 32'(wcnt[c]), 32'd188);
        chk("done_after_last", {29'd0, prev_wr, prev_ch}, {29'd0, 1'b1, 2'(c)});
      end
      if (PKT_ABORT[c]) n_abort[c]++;
    end
    if (ERR_SYNC) n_err++;
    if (HDR_VALID) begin
      if (exp_hdr_q.size() == 0) chk("hdr_unexpected", 32'(HDR_VALID), 32'h0);
      else chk("hdr_out", HDR_OUT, exp_hdr_q.pop_front());
    end
    prev_wr = |WR_REQ;
    prev_ch = WR_REQ[1] ? 2'd1 : WR_REQ[2] ? 2'd2 : WR_REQ[3] ? 2'd3 : 2'd0;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic s);
    D_VALID_IN = v;
    DATA_IN    = d;
    P_SYNC_IN  = s;
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    monitor();
  endtask

  // idle cycles carry junk data and sync so qualification by D_VALID_IN is exercised
  task automatic send_byte(input logic [7:0] d, input logic s);
    for (int g = 0; g < 8 && ($urandom_range(99) < gap_pct); g++)
      step(1'b0, 8'($urandom), 1'($urandom));
    step(1'b1, d, s);
  endtask

  task automatic send_header(input logic [31:0] hdr);
    for (int i = 0; i < 4; i++) send_byte(hdr[8*i +: 8], 1'b0);
  endtask

  task automatic send_ts(input logic [1:0] ch, input logic accepted, input int n_bytes);
    wr_t        e;
    logic [7:0] b;
    for (int i = 0; i < n_bytes; i++) begin
      b = (i == 0) ? 8'h47 : 8'($urandom);
      if (accepted) begin
        e.ch = ch; e.data = b; e.sop = (i == 0);
        exp_q.push_back(e);
      end
      send_byte(b, i == 0);
    end
    if (accepted && n_bytes == 188) exp_done[ch]++;
  endtask

  function automatic logic [31:0] make_hdr(input logic [1:0] ch);
    logic [31:0] h;
    h = $urandom;
    h[1:0] = ch;
    return h;
  endfunction

  task automatic frame(input logic [1:0] ch);
    logic [31:0] h;
    logic        acc;
    h   = make_hdr(ch);
    acc = FIFO_ROOM_OK[ch];
    if (!acc) exp_drop++;
    send_header(h);
    exp_hdr_q.push_back(h);
    send_ts(ch, acc, 188);
  endtask

  task automatic settle_and_check(input string tag);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
    chk({tag, "_wr_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_hdr_q_empty"}, 32'(exp_hdr_q.size()), 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk({tag, "_done"}, 32'(n_done[c]), 32'(exp_done[c]));
      chk({tag, "_abort"}, 32'(n_abort[c]), 32'(exp_abort[c]));
    end
    chk({tag, "_err_sync"}, 32'(n_err), 32'(exp_err));
    chk({tag, "_drop_cnt"}, 32'(DROP_CNT), 32'(exp_drop));
  endtask

  initial begin
    logic [31:0] h;
    for (int c = 0; c < 4; c++) begin
      wcnt[c] = 0; n_done[c] = 0; n_abort[c] = 0; exp_done[c] = 0; exp_abort[c] = 0;
    end

    // reset state
    repeat (3) @(negedge SYS_CLK);
    chk("rst_outputs", {DATA_OUT, WR_REQ, P_SYNC_OUT, PKT_DONE, PKT_ABORT, HDR_VALID, ERR_SYNC}, 32'h0);
    chk("rst_hdr", HDR_OUT, 32'h0);
    chk("rst_drop", 32'(DROP_CNT), 32'h0);
    chk("rst_state", 32'(state_mon), 32'd0);
    RST = 1'b1;
    step(1'b0, 8'h00, 1'b0);

    // back-to-back packets, no gaps
    gap_pct = 0;
    frame(2'd0); frame(2'd2); frame(2'd3);
    chk("b2b_state_header", 32'(state_mon), 32'd2);
    settle_and_check("b2b");

    // heavy D_VALID_IN gaps
    gap_pct = 50;
    for (int k = 0; k < 6; k++) frame(2'($urandom_range(3)));
    settle_and_check("gaps");

    // no room on ch1: packet dropped, following ch0 packet intact
    gap_pct = 25;
    FIFO_ROOM_OK = 4'b1101;
    frame(2'd1);
    chk("drop_state", 32'(state_mon), 32'd2);
    frame(2'd0);
    FIFO_ROOM_OK = 4'hF;
    settle_and_check("drop");

    // sync at payload byte 100 of a ch2 packet: abort, then the new packet is taken
    h = make_hdr(2'd2);
    send_header(h);
    exp_hdr_q.push_back(h);
    send_ts(2'd2, 1'b1, 100);
    exp_abort[2]++;
    exp_err++;
    exp_hdr_q.push_back(h);
    send_ts(2'd2, 1'b1, 188);
    settle_and_check("abort");

    // one extra byte shifts the header slot: error, hunt, relock on the 0x47
    send_byte(8'($urandom), 1'b0);
    h = make_hdr(2'd1);
    send_header(h);
    exp_err++;
    chk("misalign_state_hunt", 32'(state_mon), 32'd0);
    exp_hdr_q.push_back(h);
    send_ts(2'd1, 1'b1, 188);
    settle_and_check("misalign");

    // async reset at payload byte 50
    h = make_hdr(2'd0);
    send_header(h);
    exp_hdr_q.push_back(h);
    send_ts(2'd0, 1'b1, 50);
    RST = 1'b0;
    #1;
    chk("rst_mid_outputs", {DATA_OUT, WR_REQ, P_SYNC_OUT, PKT_DONE, PKT_ABORT, HDR_VALID, ERR_SYNC}, 32'h0);
    chk("rst_mid_state", 32'(state_mon), 32'd0);
    chk("rst_mid_hdr", HDR_OUT, 32'h0);
    exp_drop = 0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h47, 1'b1);
    RST = 1'b1;
    frame(2'd3);
    frame(2'd2);
    settle_and_check("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
